// File: rtl/pe_pkg.sv
// ----------------------------------------------------------------------------
// pe_pkg
// Definitions shared by the priority encoder and the priority decoder.
//   PE_WIDTH    number of request/decoded lines
//   PE_CODE_W   width of the binary code word, log2(PE_WIDTH)
//   pe_entry_t  one buffered decode result: {none, y}
//   buf_state_t occupancy state of the 2-entry receive buffer
// ----------------------------------------------------------------------------
package pe_pkg;

  localparam int PE_WIDTH  = 8;
  localparam int PE_CODE_W = 3;

  typedef struct packed {
    logic                none;
    logic [PE_WIDTH-1:0] y;
  } pe_entry_t;

  // The state value is the number of words held in the buffer.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_t;

endpackage

// File: rtl/pe_skid_buf.sv
// ----------------------------------------------------------------------------
// pe_skid_buf
// Two-entry valid/ready buffer, generic in data width. A word pushed on one
// edge is visible at the output after that edge; nothing passes combinationally
// from input to output. in_ready is registered.
// Ports:
//   clk       clock, all logic on posedge
//   rst       synchronous active-high reset, empties the buffer
//   i_valid   upstream word valid
//   o_ready   buffer can accept a word this cycle (registered)
//   i_data    upstream word
//   o_valid   head entry valid
//   i_ready   downstream takes the head this cycle
//   o_data    head entry
// ----------------------------------------------------------------------------
module pe_skid_buf
  import pe_pkg::*;
#(
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_data
);

  buf_state_t    r_state;
  buf_state_t    w_nextState;
  logic          r_ready;
  logic [DW-1:0] r_head;
  logic [DW-1:0] r_tail;
  logic          w_push;
  logic          w_pop;

  assign w_push  = i_valid & r_ready;
  assign w_pop   = (r_state != BUF_EMPTY) & i_ready;
  assign o_ready = r_ready;
  assign o_valid = (r_state != BUF_EMPTY);
  assign o_data  = r_head;

  // Occupancy next-state. A push and a pop together at one entry leave the
  // count unchanged; at two entries a push cannot happen because ready is low.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      BUF_EMPTY: if (w_push)            w_nextState = BUF_ONE;
      BUF_ONE: begin
        if (w_push && !w_pop)           w_nextState = BUF_TWO;
        else if (w_pop && !w_push)      w_nextState = BUF_EMPTY;
      end
      BUF_TWO:   if (w_pop)             w_nextState = BUF_ONE;
      default:                          w_nextState = r_state;
    endcase
  end

  // State register. Ready is derived from the state we are moving into so
  // that it can be a flop yet still reflect this cycle's push and pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= BUF_EMPTY;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_ready <= (w_nextState != BUF_TWO);
    end
  end

  // Data storage. The head always holds the oldest word; with one entry a
  // simultaneous push and pop writes straight into the head, and with two
  // entries a pop promotes the tail into the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      case (r_state)
        BUF_EMPTY: if (w_push) r_head <= i_data;
        BUF_ONE: begin
          if (w_push && w_pop) r_head <= i_data;
          else if (w_push)     r_tail <= i_data;
        end
        BUF_TWO:   if (w_pop)  r_head <= r_tail;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/priority_decoder.sv
// ----------------------------------------------------------------------------
// priority_decoder
// Receive side of the priority-encoder link. Decodes {A,B,C} with the
// any-request flag V into a one-hot line vector, buffers it in a 2-entry
// valid/ready buffer and keeps a sticky mask of every line delivered
// downstream since the last clear.
// Ports:
//   clk          clock, all logic on posedge
//   rst          synchronous active-high reset
//   in_valid     upstream code word valid
//   in_ready     buffer can accept a word this cycle
//   A, B, C      code word, A is the MSB
//   V            1 = request present, 0 = no request (code ignored)
//   out_valid    head entry valid
//   out_ready    downstream accepts the head this cycle
//   Y            one-hot decoded line of the head, zero when none=1
//   none         head entry was captured with V=0
//   served_mask  sticky OR of Y over all output handshakes
//   clr_mask     clear served_mask (a same-cycle set still wins)
// ----------------------------------------------------------------------------
module priority_decoder
  import pe_pkg::*;
#(
  parameter int WIDTH = PE_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             V,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             none,
  output logic [WIDTH-1:0] served_mask,
  input  logic             clr_mask
);

  localparam int CODE_W = $clog2(WIDTH);

  logic [CODE_W-1:0] w_code;
  logic [WIDTH-1:0]  w_decoded;
  pe_entry_t         w_inEntry;
  pe_entry_t         w_headEntry;
  logic              w_pop;
  logic [WIDTH-1:0]  r_mask;

  assign w_code    = {A, B, C};
  assign w_decoded = V ? (WIDTH'(1) << w_code) : '0;
  assign w_inEntry = '{none: ~V, y: w_decoded};

  pe_skid_buf #(
    .DW($bits(pe_entry_t))
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  (w_inEntry),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (w_headEntry)
  );

  assign Y           = out_valid ? w_headEntry.y : '0;
  assign none        = out_valid & w_headEntry.none;
  assign w_pop       = out_valid & out_ready;
  assign served_mask = r_mask;

  // Sticky served mask. A clear replaces the mask with whatever is being
  // delivered this cycle, so a line popped during a clear is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask <= '0;
    end else if (clr_mask) begin
      r_mask <= (w_pop && !none) ? Y : '0;
    end else if (w_pop && !none) begin
      r_mask <= r_mask | Y;
    end
  end

endmodule

// File: tb/tb_priority_decoder.sv
// ----------------------------------------------------------------------------
// tb_priority_decoder
// Self-checking bench for priority_decoder. A queue-based reference model of
// the receive buffer and served mask is advanced once per clock alongside the
// DUT; each scenario task compares DUT outputs with the model and with the
// literal values the scenario expects.
// ----------------------------------------------------------------------------
module tb_priority_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inValid = 1'b0;
  logic       inReady;
  logic [2:0] code = 3'd0;
  logic       V = 1'b0;
  logic       outValid;
  logic       outReady = 1'b0;
  logic [7:0] Y;
  logic       none;
  logic [7:0] servedMask;
  logic       clrMask = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [8:0] modelQ[$];
  logic [7:0] modelMask = 8'h00;
  logic       modelReady = 1'b0;

  always #5 clk = ~clk;

  priority_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (inValid),
    .in_ready    (inReady),
    .A           (code[2]),
    .B           (code[1]),
    .C           (code[0]),
    .V           (V),
    .out_valid   (outValid),
    .out_ready   (outReady),
    .Y           (Y),
    .none        (none),
    .served_mask (servedMask),
    .clr_mask    (clrMask)
  );

  // Expected head values as seen by the model.
  function automatic logic expValid();
    return modelQ.size() > 0;
  endfunction

  function automatic logic [7:0] expY();
    logic [8:0] e;
    if (modelQ.size() == 0) return 8'h00;
    e = modelQ[0];
    return e[7:0];
  endfunction

  function automatic logic expNone();
    logic [8:0] e;
    if (modelQ.size() == 0) return 1'b0;
    e = modelQ[0];
    return e[8];
  endfunction

  // Advance one clock: decide the handshakes from the current inputs and the
  // model occupancy, let the edge happen, update the model, then wait #1 so
  // outputs are sampled away from the edge.
  task automatic stepCycle();
    logic       doPush;
    logic       doPop;
    logic [8:0] head;
    doPush = inValid && modelReady;
    doPop  = (modelQ.size() > 0) && outReady;
    @(posedge clk);
    if (rst) begin
      modelQ.delete();
      modelMask  = 8'h00;
      modelReady = 1'b0;
    end else begin
      head = 9'h000;
      if (doPop) head = modelQ.pop_front();
      if (clrMask) modelMask = (doPop && !head[8]) ? head[7:0] : 8'h00;
      else if (doPop && !head[8]) modelMask = modelMask | head[7:0];
      if (doPush) modelQ.push_back(V ? {1'b0, 8'(2 ** code)} : {1'b1, 8'h00});
      modelReady = (modelQ.size() < 2);
    end
    #1;
  endtask

  task automatic applyStimulus(input logic iv, input logic [2:0] c, input logic v,
                               input logic ordy, input logic clr);
    inValid  = iv;
    code     = c;
    V        = v;
    outReady = ordy;
    clrMask  = clr;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    stepCycle();
    stepCycle();
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b exp 0", outValid); end
    checks++; if (Y !== 8'h00) begin errors++; $display("[TB] FAIL reset_Y got %h exp 00", Y); end
    checks++; if (none !== 1'b0) begin errors++; $display("[TB] FAIL reset_none got %b exp 0", none); end
    checks++; if (servedMask !== 8'h00) begin errors++; $display("[TB] FAIL reset_mask got %h exp 00", servedMask); end
    checks++; if (inReady !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready got %b exp 0", inReady); end
    rst = 1'b0;
    stepCycle();
    checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_in_ready got %b exp 1", inReady); end
  endtask

  task automatic test_single();
    applyStimulus(1'b1, 3'b111, 1'b1, 1'b1, 1'b0);
    stepCycle();
    inValid = 1'b0;
    checks++; if (outValid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid got %b exp 1", outValid); end
    checks++; if (Y !== 8'h80) begin errors++; $display("[TB] FAIL single_Y got %h exp 80", Y); end
    checks++; if (none !== 1'b0) begin errors++; $display("[TB] FAIL single_none got %b exp 0", none); end
    stepCycle();
    checks++; if (servedMask !== 8'h80) begin errors++; $display("[TB] FAIL single_mask got %h exp 80", servedMask); end
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL single_drained got %b exp 0", outValid); end
  endtask

  task automatic test_sweep();
    for (int c = 7; c >= 0; c--) begin
      applyStimulus(1'b1, 3'(c), 1'b1, 1'b1, 1'b0);
      stepCycle();
      checks++; if (outValid !== 1'b1) begin errors++; $display("[TB] FAIL sweep_valid code %0d got %b exp 1", c, outValid); end
      checks++; if (Y !== 8'(1 << c)) begin errors++; $display("[TB] FAIL sweep_Y code %0d got %h exp %h", c, Y, 8'(1 << c)); end
      checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL sweep_ready code %0d got %b exp 1", c, inReady); end
    end
    inValid = 1'b0;
    stepCycle();
    checks++; if (servedMask !== 8'hFF) begin errors++; $display("[TB] FAIL sweep_mask got %h exp FF", servedMask); end
  endtask

  task automatic test_none();
    applyStimulus(1'b1, 3'b101, 1'b0, 1'b0, 1'b0);
    stepCycle();
    inValid = 1'b0;
    checks++; if (Y !== 8'h00) begin errors++; $display("[TB] FAIL none_Y got %h exp 00", Y); end
    checks++; if (none !== 1'b1) begin errors++; $display("[TB] FAIL none_flag got %b exp 1", none); end
    outReady = 1'b1;
    stepCycle();
    checks++; if (servedMask !== 8'hFF) begin errors++; $display("[TB] FAIL none_mask got %h exp FF", servedMask); end
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL none_drained got %b exp 0", outValid); end
  endtask

  task automatic test_backpressure();
    applyStimulus(1'b1, 3'b010, 1'b1, 1'b0, 1'b0);
    stepCycle();
    code = 3'b011;
    stepCycle();
    code = 3'b100;
    checks++; if (inReady !== 1'b0) begin errors++; $display("[TB] FAIL bp_full_ready got %b exp 0", inReady); end
    checks++; if (Y !== 8'h04) begin errors++; $display("[TB] FAIL bp_head_held got %h exp 04", Y); end
    stepCycle();
    checks++; if (Y !== 8'h04) begin errors++; $display("[TB] FAIL bp_head_stable got %h exp 04", Y); end
    outReady = 1'b1;
    stepCycle();
    checks++; if (Y !== 8'h08) begin errors++; $display("[TB] FAIL bp_second got %h exp 08", Y); end
    checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_again got %b exp 1", inReady); end
    stepCycle();
    inValid = 1'b0;
    checks++; if (Y !== 8'h10) begin errors++; $display("[TB] FAIL bp_third got %h exp 10", Y); end
    stepCycle();
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drained got %b exp 0", outValid); end
  endtask

  task automatic test_clear();
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    stepCycle();
    clrMask = 1'b0;
    checks++; if (servedMask !== 8'h00) begin errors++; $display("[TB] FAIL clr_plain got %h exp 00", servedMask); end
    for (int c = 4; c < 8; c++) begin
      applyStimulus(1'b1, 3'(c), 1'b1, 1'b1, 1'b0);
      stepCycle();
    end
    applyStimulus(1'b1, 3'b001, 1'b1, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (servedMask !== 8'hF0) begin errors++; $display("[TB] FAIL clr_setup_mask got %h exp F0", servedMask); end
    checks++; if (Y !== 8'h02) begin errors++; $display("[TB] FAIL clr_setup_head got %h exp 02", Y); end
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    stepCycle();
    clrMask = 1'b0;
    checks++; if (servedMask !== 8'h02) begin errors++; $display("[TB] FAIL clr_set_wins got %h exp 02", servedMask); end
  endtask

  task automatic test_reset_mid();
    applyStimulus(1'b1, 3'b110, 1'b1, 1'b0, 1'b0);
    stepCycle();
    code = 3'b011;
    stepCycle();
    inValid = 1'b0;
    checks++; if (inReady !== 1'b0) begin errors++; $display("[TB] FAIL rmid_full got %b exp 0", inReady); end
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_valid got %b exp 0", outValid); end
    checks++; if (servedMask !== 8'h00) begin errors++; $display("[TB] FAIL rmid_mask got %h exp 00", servedMask); end
    outReady = 1'b1;
    stepCycle();
    checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL rmid_ready got %b exp 1", inReady); end
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_stale cycle %0d got %b exp 0", i, outValid); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 2) != 0),
                    1'($urandom_range(0, 15) == 0));
      rst = ($urandom_range(0, 63) == 0);
      stepCycle();
      checks++; if (outValid !== expValid()) begin errors++; $display("[TB] FAIL rnd_valid cyc %0d got %b exp %b", i, outValid, expValid()); end
      checks++; if (Y !== expY()) begin errors++; $display("[TB] FAIL rnd_Y cyc %0d got %h exp %h", i, Y, expY()); end
      checks++; if (none !== expNone()) begin errors++; $display("[TB] FAIL rnd_none cyc %0d got %b exp %b", i, none, expNone()); end
      checks++; if (servedMask !== modelMask) begin errors++; $display("[TB] FAIL rnd_mask cyc %0d got %h exp %h", i, servedMask, modelMask); end
      checks++; if (inReady !== modelReady) begin errors++; $display("[TB] FAIL rnd_ready cyc %0d got %b exp %b", i, inReady, modelReady); end
    end
    rst = 1'b0;
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #2;
    test_reset();
    test_single();
    test_sweep();
    test_none();
    test_backpressure();
    test_clear();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
